// File: rtl/page_buf_writer.sv
// page_buf_writer: write side of the ping-pong page buffer feeding the NAND
// program path. Streams bytes into the bank chosen by ram_adj. A page closes
// when it fills or when a flush arrives. A flushed page is padded to its end.
// After a page closes, the block raises change_ram and waits for the
// RAM-switch unit to report that the banks have swapped.
//
// Handshake: a byte moves on any rising clk edge where din_valid and
// din_ready are both high. din_ready does not depend on din_valid. A producer
// may hold din_valid high while din_ready is low; no byte is lost or
// duplicated.
//
// dbg_state exposes the FSM state (FILL=0, PAD=1, CLOSE=2, REQ=3, WAIT_SW=4).
// Checkers and debug tooling use this port.

module page_buf_writer #(
    parameter int          PAGE_BYTES = 2048,
    parameter int          ADDR_W     = 11,
    parameter logic [7:0]  PAD_BYTE   = 8'hFF,
    parameter int          REQ_HOLD   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        din,
    input  logic              din_valid,
    output logic              din_ready,
    input  logic              flush,
    input  logic              ram_adj,
    input  logic              ram_change,
    output logic              wr_en_a,
    output logic              wr_en_b,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              change_ram,
    output logic              page_done,
    output logic              page_bank,
    output logic [ADDR_W:0]   page_fill,
    output logic [2:0]        dbg_state
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PAGE_BYTES - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   FULL_FILL = (ADDR_W+1)'(PAGE_BYTES);
    localparam int                HOLD_W    = (REQ_HOLD > 1) ? $clog2(REQ_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(REQ_HOLD - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

    typedef enum logic [2:0] {
        S_FILL    = 3'd0,
        S_PAD     = 3'd1,
        S_CLOSE   = 3'd2,
        S_REQ     = 3'd3,
        S_WAIT_SW = 3'd4
    } state_t;

    state_t              state;
    state_t              state_nx;
    logic [ADDR_W-1:0]   cnt;        // next byte address within the page
    logic [ADDR_W:0]     fill_q;     // real byte count of the page being closed
    logic [HOLD_W-1:0]   hold_cnt;   // cycles spent in REQ so far
    logic                bank_q;     // bank of the most recent accepted byte

    logic                accept;
    logic                at_last;
    logic [ADDR_W:0]     fill_eff;
    logic                flush_take;

    // A byte is accepted only in FILL, and never while reset is held.
    assign din_ready  = (state == S_FILL) && !rst;
    assign accept     = din_valid && din_ready;
    assign at_last    = (cnt == LAST_ADDR);

    // A byte accepted together with a flush still counts toward the fill.
    // A flush closes the page only when the page holds at least one real byte.
    assign fill_eff   = {1'b0, cnt} + {{ADDR_W{1'b0}}, accept};
    assign flush_take = (state == S_FILL) && flush && (fill_eff != '0);

    // The close and request outputs are decoded from the state. They are
    // forced low while reset is held, so an aborted page never signals.
    assign change_ram = (state == S_REQ) && !rst;
    assign page_done  = (state == S_CLOSE) && !rst;
    assign page_bank  = page_done && ram_adj;
    assign page_fill  = page_done ? fill_q : '0;
    assign dbg_state  = state;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FILL;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            S_FILL: begin
                if (accept && at_last) begin
                    // Closing on the last byte takes priority: nothing is left to pad.
                    state_nx = S_CLOSE;
                end else if (flush_take) begin
                    state_nx = S_PAD;
                end
            end
            S_PAD: begin
                if (at_last) begin
                    state_nx = S_CLOSE;
                end
            end
            S_CLOSE: begin
                state_nx = S_REQ;
            end
            S_REQ: begin
                if (hold_cnt == HOLD_LAST) begin
                    state_nx = S_WAIT_SW;
                end
            end
            S_WAIT_SW: begin
                // There is no timeout. The switch unit may hold off indefinitely.
                if (ram_change) begin
                    state_nx = S_FILL;
                end
            end
            default: begin
                state_nx = S_FILL;
            end
        endcase
    end

    // Page bookkeeping: address counter, fill count, request hold timer, write bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            fill_q   <= '0;
            hold_cnt <= '0;
            bank_q   <= 1'b0;
        end else begin
            case (state)
                S_FILL: begin
                    if (accept) begin
                        // After the last address the counter wraps to 0, and the
                        // FSM moves to CLOSE on the same edge.
                        cnt    <= cnt + ADDR_ONE;
                        bank_q <= ram_adj;
                    end
                    if (accept && at_last) begin
                        fill_q <= FULL_FILL;
                    end else if (flush_take) begin
                        fill_q <= fill_eff;
                    end
                end
                S_PAD: begin
                    cnt      <= cnt + ADDR_ONE;
                    hold_cnt <= '0;
                end
                S_CLOSE: begin
                    cnt      <= '0;
                    hold_cnt <= '0;
                end
                S_REQ: begin
                    hold_cnt <= hold_cnt + HOLD_ONE;
                end
                default: begin
                    hold_cnt <= '0;
                end
            endcase
        end
    end

    // Write port: registered one cycle after the accept or the pad step.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en_a <= 1'b0;
            wr_en_b <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en_a <= 1'b0;
            wr_en_b <= 1'b0;
            if (accept) begin
                // Sample the bank on every accept, so bytes after a swap land
                // in the new bank.
                wr_en_a <= ~ram_adj;
                wr_en_b <= ram_adj;
                wr_addr <= cnt;
                wr_data <= din;
            end else if (state == S_PAD) begin
                // Pad the page that already holds this page's bytes.
                wr_en_a <= ~bank_q;
                wr_en_b <= bank_q;
                wr_addr <= cnt;
                wr_data <= PAD_BYTE;
            end
        end
    end

    // The two bank strobes are mutually exclusive.
    a_wr_en_excl: assert property (@(posedge clk) disable iff (rst) !(wr_en_a && wr_en_b));

endmodule
